// File: rtl/io_bus_arbiter.sv
// Two-port round-robin arbiter in front of the memory-mapped IO block, with a
// latency-matched tag pipeline that routes read data back. Optional grant lock: IO_ARB_LOCK_EN.
module io_bus_arbiter #(
    parameter int READ_LATENCY = 2  // io_* issue to valid io_data_out, 1..4
) (
    input  logic        main_clk,
    input  logic        main_rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [15:0] req0_wdata,
    input  logic        req0_write,
    input  logic        req0_byte,
    input  logic        req0_lock,
    output logic        req0_rvalid,
    output logic [15:0] req0_rdata,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [15:0] req1_wdata,
    input  logic        req1_write,
    input  logic        req1_byte,
    input  logic        req1_lock,
    output logic        req1_rvalid,
    output logic [15:0] req1_rdata,

    output logic [31:0] io_address,
    output logic [15:0] io_data_in,
    output logic [1:0]  io_control,
    input  logic [15:0] io_data_out
);

    logic                    last_grant;
    logic                    accept0;
    logic                    accept1;
    logic                    accept;
    logic                    sel;
    logic                    issue_tag_valid;
    logic                    issue_tag_port;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [READ_LATENCY-1:0] tag_port;
    logic                    tag_out_valid;
    logic                    tag_out_port;

`ifdef IO_ARB_LOCK_EN
    logic locked;
    logic lock_owner;
    logic sel_lock;

    // While locked only the owner may be granted; otherwise plain round-robin.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (locked) begin
            if (lock_owner) req1_ready = req1_valid;
            else            req0_ready = req0_valid;
        end else if (req0_valid && req1_valid) begin
            req0_ready = last_grant;
            req1_ready = ~last_grant;
        end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
        end
    end

    assign sel_lock = sel ? req1_lock : req0_lock;

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (accept) begin
            if (sel_lock) begin
                locked     <= 1'b1;
                lock_owner <= sel;
            end else if (locked && (lock_owner == sel)) begin
                locked     <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = req0_lock ^ req1_lock;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            req0_ready = last_grant;
            req1_ready = ~last_grant;
        end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
        end
    end
`endif

    assign accept0 = req0_valid & req0_ready;
    assign accept1 = req1_valid & req1_ready;
    assign accept  = accept0 | accept1;
    assign sel     = accept1;

    // Issue stage: one cycle on io_*, then back to a harmless non-IO read.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            io_address      <= '0;
            io_data_in      <= '0;
            io_control      <= '0;
            last_grant      <= 1'b1;
            issue_tag_valid <= 1'b0;
            issue_tag_port  <= 1'b0;
        end else if (accept) begin
            io_address      <= sel ? req1_addr  : req0_addr;
            io_data_in      <= sel ? req1_wdata : req0_wdata;
            io_control      <= sel ? {req1_write, req1_byte} : {req0_write, req0_byte};
            last_grant      <= sel;
            issue_tag_valid <= sel ? ~req1_write : ~req0_write;
            issue_tag_port  <= sel;
        end else begin
            io_address      <= '0;
            io_control      <= '0;
            issue_tag_valid <= 1'b0;
            issue_tag_port  <= 1'b0;
        end
    end

    // Tag leaves the pipeline in the cycle io_data_out answers the matching issue.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid[0] <= issue_tag_valid;
            tag_port[0]  <= issue_tag_port;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
            end
        end
    end

    assign tag_out_valid = tag_valid[READ_LATENCY-1];
    assign tag_out_port  = tag_port[READ_LATENCY-1];

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_rvalid <= tag_out_valid & ~tag_out_port;
            req1_rvalid <= tag_out_valid &  tag_out_port;
            if (tag_out_valid && !tag_out_port) req0_rdata <= io_data_out;
            if (tag_out_valid &&  tag_out_port) req1_rdata <= io_data_out;
        end
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO port (LEDs, VGA VRAM, SD controller, PS/2 controller) between two requesters: port 0 = CPU, port 1 = DMA/blit engine.
- Round-robin, valid/ready accepted transactions, one issue per cycle, fully pipelined.
- Returns read data to the originating port using a latency-matched tag pipeline.
- Sits between the requesters and the IO block's address_io/data_in_io/control_io/data_out_io port.

Parameters:
- READ_LATENCY, 2, cycles from a request driven on io_* to valid data on io_data_out; range 1..4.

Ports:
- main_clk  in  1  system clock; sole clock.
- main_rst_n  in  1  asynchronous active-low reset.
- req0_valid, req1_valid  in  1  request present; must be held stable until ready.
- req0_ready, req1_ready  out  1  request accepted this cycle when valid & ready.
- req0_addr, req1_addr  in  32  byte address; bit 31 set = IO space.
- req0_wdata, req1_wdata  in  16  write data.
- req0_write, req1_write  in  1  1 = write, 0 = read.
- req0_byte, req1_byte  in  1  byte operation.
- req0_lock, req1_lock  in  1  hold grant after this transaction (optional feature only).
- req0_rvalid, req1_rvalid  out  1  one-cycle read-data pulse.
- req0_rdata, req1_rdata  out  16  read data, valid with rvalid.
- io_address  out  32  to IO block address_io.
- io_data_in  out  16  to IO block data_in_io.
- io_control  out  2  {write, byte} to IO block control_io.
- io_data_out  in  16  from IO block data_out_io.

Behaviour:
- Reset: io_address = 0, io_data_in = 0, io_control = 0, all readys/rvalids/rdata = 0, last_grant = 1 (port 0 wins first tie), tag pipeline cleared, lock released.
- Grant (combinational):
  - Only one valid: that port is ready.
  - Both valid: the port other than last_grant is ready.
  - No valid: no ready.
  - At most one ready per cycle.
- Issue stage (registered): on accept, io_address/io_data_in/io_control load the request (io_control = {write, byte}) for exactly one cycle, and last_grant updates.
- Idle: with no accept, next cycle io_control = 0 and io_address = 0 (non-IO space, harmless read); io_data_in holds its old value.
- Writes:
  - io_control[1] is high for exactly one cycle per write.
  - No response is generated.
  - Two back-to-back writes from the same port are issued on consecutive cycles if uncontested.
- Reads:
  - Issue pushes tag {valid, port} into a shift register of depth READ_LATENCY.
  - When the tag exits, io_data_out is registered into that port's rdata, and rvalid pulses on the following cycle.
  - Accept-to-rvalid = READ_LATENCY + 2 cycles (default 4), fixed and independent of contention.
  - Responses return in issue order.
  - rdata holds its last value when rvalid is low.
- Back-to-back reads: one per cycle sustained; rvalid may be asserted on consecutive cycles, interleaved between ports.
- Starvation: with both ports continuously valid, grants strictly alternate 0,1,0,1.
- Reset mid-operation:
  - Asynchronous clear of all tags; no rvalid is produced for in-flight reads.
  - A write already presented on io_* may still complete in the IO block. This is accepted and documented.
- The arbiter performs no address decode and no byte-lane manipulation; the IO block handles byte lanes.

Optional Feature:
- Macro: IO_ARB_LOCK_EN.
- Defined:
  - Accepting a request with reqN_lock = 1 sets lock_owner = N.
  - While locked, only port N can be ready; the other port waits regardless of round-robin.
  - Lock releases on the first accepted port-N transaction with lock = 0.
  - Reset clears the lock.
  - Use case: multi-access SD/PS/2 sequences.
- Undefined: lock inputs are ignored (no logic), and arbitration is pure round-robin.

Test Plan:
- Port 0 only, read 0x8080_0004 at cycle 10, io_data_out = 0x1234 at cycle 13 -> io_address = 0x8080_0004 at cycle 11, req0_rvalid at cycle 14 with rdata 0x1234; req1_rvalid stays 0.
- Both valid continuously for 8 cycles, reads -> grants 0,1,0,1,0,1,0,1; rvalids return in the same order, each 4 cycles after accept, one per cycle.
- Port 1 byte write 0x8000_0003, wdata 0x0001 -> io_control = 2'b11 for exactly one cycle, io_data_in = 0x0001; no rvalid on either port.
- Reset asserted 1 cycle after two reads are accepted -> all outputs 0 immediately; no rvalid after reset release; first contested grant goes to port 0.
- IO_ARB_LOCK_EN: port 1 issues a lock = 1 write, then port 0 and port 1 both valid for 3 cycles (port 1 lock = 1, 1, 0) -> only port 1 is granted for those 3 transactions, port 0 is granted next. Without the macro -> alternating grants.
